// File: rtl/syncfifo_mc.sv
// Single-clock multi-channel FIFO: ch_num logical FIFOs of data_depth words sharing one array.
// Optional sticky overflow/underflow flags are enabled by defining SYNCFIFO_MC_ERR_EN.
module syncfifo_mc #(
  parameter int data_width  = 8,
  parameter int data_depth  = 32,
  parameter int depth_width = 5,
  parameter int ch_num      = 4,
  parameter int ch_width    = 2
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                wr,
  input  logic [ch_width-1:0]                 wr_ch,
  input  logic [data_width-1:0]               wr_data,
  input  logic                                rd,
  input  logic [ch_width-1:0]                 rd_ch,
  output logic [data_width-1:0]               rd_data,
  output logic                                rd_data_vld,
  output logic [ch_width-1:0]                 rd_data_ch,
  input  logic [depth_width:0]                cfg_almost_full,
  input  logic [depth_width:0]                cfg_almost_empty,
  output logic [ch_num-1:0]                   full,
  output logic [ch_num-1:0]                   empty,
  output logic [ch_num-1:0]                   almost_full,
  output logic [ch_num-1:0]                   almost_empty,
  output logic [ch_num*(depth_width+1)-1:0]   ch_cnt,
  output logic                                ovf_err,
  output logic                                udf_err,
  input  logic                                err_clr
);

  localparam int CW1 = depth_width + 1;
  localparam int AW  = ch_width + depth_width;
  localparam logic [CW1-1:0] DEPTH_CNT = CW1'(data_depth);
  localparam logic [CW1-1:0] ONE       = CW1'(1);

  logic [data_width-1:0] mem [ch_num*data_depth];

  logic [CW1-1:0] wptr_q [ch_num];
  logic [CW1-1:0] wptr_d [ch_num];
  logic [CW1-1:0] rptr_q [ch_num];
  logic [CW1-1:0] rptr_d [ch_num];
  logic [CW1-1:0] cnt_q  [ch_num];
  logic [CW1-1:0] cnt_d  [ch_num];

  logic [data_width-1:0] rd_data_q, rd_data_d;
  logic                  rd_data_vld_q, rd_data_vld_d;
  logic [ch_width-1:0]   rd_data_ch_q, rd_data_ch_d;

  logic                   wr_blk, rd_blk, wr_acc, rd_acc;
  logic [depth_width-1:0] wr_ptr_sel, rd_ptr_sel;
  logic [AW-1:0]          wr_addr, rd_addr;
  logic [ch_num-1:0]      wr_hit, rd_hit;

  always_comb begin
    full         = '0;
    empty        = '0;
    almost_full  = '0;
    almost_empty = '0;
    ch_cnt       = '0;
    for (int i = 0; i < ch_num; i++) begin
      full[i]                 = (cnt_q[i] == DEPTH_CNT);
      empty[i]                = (cnt_q[i] == '0);
      almost_full[i]          = (cnt_q[i] >= cfg_almost_full);
      almost_empty[i]         = (cnt_q[i] <= cfg_almost_empty);
      ch_cnt[i*CW1 +: CW1]    = cnt_q[i];
    end
  end

  // An out-of-range channel index matches no channel and is treated as blocked.
  always_comb begin
    wr_blk     = 1'b1;
    rd_blk     = 1'b1;
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int i = 0; i < ch_num; i++) begin
      if (wr_ch == ch_width'(i)) begin
        wr_blk     = full[i];
        wr_ptr_sel = wptr_q[i][depth_width-1:0];
      end
      if (rd_ch == ch_width'(i)) begin
        rd_blk     = empty[i];
        rd_ptr_sel = rptr_q[i][depth_width-1:0];
      end
    end
    wr_acc  = wr & ~wr_blk;
    rd_acc  = rd & ~rd_blk;
    wr_addr = {wr_ch, wr_ptr_sel};
    rd_addr = {rd_ch, rd_ptr_sel};
  end

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int i = 0; i < ch_num; i++) begin
      wr_hit[i] = wr_acc && (wr_ch == ch_width'(i));
      rd_hit[i] = rd_acc && (rd_ch == ch_width'(i));
      wptr_d[i] = wr_hit[i] ? wptr_q[i] + ONE : wptr_q[i];
      rptr_d[i] = rd_hit[i] ? rptr_q[i] + ONE : rptr_q[i];
      case ({wr_hit[i], rd_hit[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    rd_data_d     = rd_acc ? mem[rd_addr] : rd_data_q;
    rd_data_vld_d = rd_acc;
    rd_data_ch_d  = rd_acc ? rd_ch : rd_data_ch_q;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ch_num; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rd_data_q     <= '0;
      rd_data_vld_q <= 1'b0;
      rd_data_ch_q  <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
      rd_data_q     <= rd_data_d;
      rd_data_vld_q <= rd_data_vld_d;
      rd_data_ch_q  <= rd_data_ch_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_data_vld = rd_data_vld_q;
  assign rd_data_ch  = rd_data_ch_q;

`ifdef SYNCFIFO_MC_ERR_EN
  logic ovf_err_q, ovf_err_d;
  logic udf_err_q, udf_err_d;

  // Clear has priority over a set arriving in the same cycle.
  always_comb begin
    ovf_err_d = ovf_err_q | (wr & wr_blk);
    udf_err_d = udf_err_q | (rd & rd_blk);
    if (err_clr) begin
      ovf_err_d = 1'b0;
      udf_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
  assign udf_err = udf_err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf_err        = 1'b0;
  assign udf_err        = 1'b0;
`endif

endmodule
